// File: rtl/work_receiver_if.sv
// Byte-stream in / assembled-frame out bundle between the UART RX side and work_handler.
// The master drives the receive stream and the acknowledge; the receiver (slave) returns the frame.
interface work_receiver_if #(
    parameter int WORK_BYTES = 80
);
    logic [7:0]              rx_data;
    logic                    new_rx_data;
    logic                    got_work;
    logic                    new_work;
    logic [8*WORK_BYTES-1:0] work_data;
    logic                    busy;
    logic                    frame_error;
    logic                    overrun;
    logic [6:0]              bytes_rcvd;

    modport master (
        output rx_data, new_rx_data, got_work,
        input  new_work, work_data, busy, frame_error, overrun, bytes_rcvd
    );

    modport slave (
        input  rx_data, new_rx_data, got_work,
        output new_work, work_data, busy, frame_error, overrun, bytes_rcvd
    );
endinterface

// File: rtl/work_receiver.sv
// Assembles one SYNC-prefixed frame of WORK_BYTES bytes from the RX byte strobe stream and
// holds it on work_data with new_work until work_handler acknowledges with got_work.
//
//  state     | meaning
//  S_IDLE    | hunting for SYNC_BYTE; every other byte is discarded
//  S_COLLECT | storing payload bytes into the staging register; inter-byte timer running
//  S_PRESENT | frame published on work_data, new_work high, waiting for got_work
module work_receiver #(
    parameter int         WORK_BYTES     = 80,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50_000_000
) (
    input logic            clk,
    input logic            rst_n,
    work_receiver_if.slave bus
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int              DW         = 8 * WORK_BYTES;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]      LAST_IDX   = 7'(WORK_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_stage;
    logic [DW-1:0]   r_work_data;
    logic [6:0]      r_bytes;
    logic [TW-1:0]   r_timer;
    logic            r_new_work;
    logic            r_busy;
    logic            r_frame_error;
    logic            r_overrun;

    logic [DW-1:0]   w_stage_next;
    logic            w_strobe;

    assign w_strobe = bus.new_rx_data;

    // Staging value including the current byte, so the final byte can go straight to work_data.
    always_comb begin
        w_stage_next = r_stage;
        for (int k = 0; k < WORK_BYTES; k++) begin
            if (r_bytes == 7'(k)) begin
                w_stage_next[8*k +: 8] = bus.rx_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_stage       <= '0;
            r_work_data   <= '0;
            r_bytes       <= '0;
            r_timer       <= '0;
            r_new_work    <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_strobe && (bus.rx_data == SYNC_BYTE)) begin
                        r_state <= S_COLLECT;
                        r_bytes <= '0;
                        r_timer <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (w_strobe) begin
                        // A byte on the expiry cycle still counts; the timer simply restarts.
                        r_stage <= w_stage_next;
                        r_bytes <= r_bytes + 7'd1;
                        r_timer <= '0;
                        if (r_bytes == LAST_IDX) begin
                            r_work_data <= w_stage_next;
                            r_new_work  <= 1'b1;
                            r_state     <= S_PRESENT;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_frame_error <= 1'b1;
                        r_bytes       <= '0;
                        r_timer       <= '0;
                        r_busy        <= 1'b0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_PRESENT: begin
                    if (w_strobe) begin
                        r_overrun <= 1'b1;
                    end
                    if (bus.got_work) begin
                        r_new_work <= 1'b0;
                        r_bytes    <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_new_work <= 1'b0;
                    r_busy     <= 1'b0;
                    r_bytes    <= '0;
                    r_timer    <= '0;
                end
            endcase
        end
    end

    assign bus.new_work    = r_new_work;
    assign bus.work_data   = r_work_data;
    assign bus.busy        = r_busy;
    assign bus.frame_error = r_frame_error;
    assign bus.overrun     = r_overrun;
    assign bus.bytes_rcvd  = r_bytes;

endmodule

// File: tb/tb_work_receiver.sv
// Bench for work_receiver: directed frame scenarios plus randomized traffic, each cycle
// compared against a queue-based frame model.
module tb_work_receiver;

    localparam int         WB   = 80;
    localparam int         TO   = 100;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         W    = 8 * WB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    work_receiver_if #(.WORK_BYTES(WB)) bus ();

    work_receiver #(
        .WORK_BYTES(WB),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = hunting, 1 = collecting, 2 = presenting
    int           phase;
    logic [7:0]   q[$];
    logic [W-1:0] m_work;
    int           silent;
    logic         m_ferr;
    logic         m_ovr;
    logic         nw_hist;
    logic         auto_ack;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        q.delete();
        m_work  = '0;
        silent  = 0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
        nw_hist = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic [7:0] d, input logic g);
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        if (phase == 0) begin
            if (s && d == SYNC) begin
                phase = 1;
                q.delete();
                silent = 0;
            end
        end else if (phase == 1) begin
            if (s) begin
                q.push_back(d);
                silent = 0;
                if (q.size() == WB) begin
                    for (int k = 0; k < WB; k++) m_work[8*k +: 8] = q[k];
                    phase = 2;
                end
            end else begin
                silent++;
                if (silent == TO) begin
                    m_ferr = 1'b1;
                    q.delete();
                    phase = 0;
                end
            end
        end else begin
            if (s) m_ovr = 1'b1;
            if (g) begin
                phase = 0;
                q.delete();
            end
        end
    endtask

    task automatic check_outputs();
        check_val("new_work",    W'(bus.new_work),    W'(phase == 2));
        check_val("busy",        W'(bus.busy),        W'(phase != 0));
        check_val("frame_error", W'(bus.frame_error), W'(m_ferr));
        check_val("overrun",     W'(bus.overrun),     W'(m_ovr));
        check_val("bytes_rcvd",  W'(bus.bytes_rcvd),  W'(q.size()));
        check_val("work_data",   bus.work_data,       m_work);
    endtask

    task automatic cycle(input logic s, input logic [7:0] d, input logic g);
        logic g_eff;
        @(negedge clk);
        g_eff           = auto_ack ? nw_hist : g;
        nw_hist         = (phase == 2);
        bus.new_rx_data = s;
        bus.rx_data     = d;
        bus.got_work    = g_eff;
        @(posedge clk);
        model_step(s, d, g_eff);
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d);
        cycle(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n, input logic g);
        repeat (n) cycle(1'b0, 8'($urandom), g);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus.new_rx_data = 1'b0;
        bus.got_work    = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int           ferr_at;
    int           r;
    logic [W-1:0] exp_word;
    logic [7:0]   b;

    initial begin
        bus.rx_data     = '0;
        bus.new_rx_data = 1'b0;
        bus.got_work    = 1'b0;
        auto_ack        = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_outputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: counting frame with got_work following new_work one cycle late
        auto_ack = 1'b1;
        send(SYNC);
        for (int i = 0; i < WB; i++) send(8'(i));
        idle(4, 1'b0);
        auto_ack = 1'b0;
        check_val("t1_byte0",   W'(bus.work_data[7:0]),     W'(8'h00));
        check_val("t1_byte79",  W'(bus.work_data[639:632]), W'(8'h4F));
        check_val("t1_top32",   W'(bus.work_data[639:608]), W'(32'h4F4E4D4C));
        check_val("t1_bytes",   W'(bus.bytes_rcvd),         W'(0));

        // 2: junk before sync, constant payload
        send(8'h11);
        send(8'h22);
        check_val("t2_junk_busy", W'(bus.busy), W'(0));
        send(SYNC);
        check_val("t2_sync_busy", W'(bus.busy), W'(1));
        for (int i = 0; i < WB; i++) send(8'h5A);
        exp_word = {WB{8'h5A}};
        check_val("t2_word", bus.work_data, exp_word);
        cycle(1'b0, 8'h00, 1'b1);

        // 3: partial frame then silence
        send(SYNC);
        for (int i = 0; i < 10; i++) send(8'($urandom));
        ferr_at = -1;
        for (int i = 1; i <= TO + 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            if (bus.frame_error) ferr_at = i;
        end
        check_val("t3_ferr_at", W'(ferr_at),       W'(TO));
        check_val("t3_busy",    W'(bus.busy),      W'(0));
        check_val("t3_word",    bus.work_data,     exp_word);

        // 4: overrun while presenting
        send(SYNC);
        for (int i = 0; i < WB; i++) send(8'($urandom));
        exp_word = m_work;
        idle(3, 1'b0);
        send(8'h33);
        check_val("t4_overrun", W'(bus.overrun), W'(1));
        idle(2, 1'b0);
        check_val("t4_word",    bus.work_data,   exp_word);
        cycle(1'b0, 8'h00, 1'b1);
        check_val("t4_idle",    W'(bus.busy),    W'(0));

        // 5: reset in the middle of a frame, then a clean frame
        send(SYNC);
        for (int i = 0; i < 40; i++) send(8'($urandom));
        do_reset();
        send(SYNC);
        for (int i = 0; i < WB; i++) send(8'(8'hC0 ^ i));
        check_val("t5_byte0", W'(bus.work_data[7:0]), W'(8'hC0));
        cycle(1'b0, 8'h00, 1'b1);

        // 6: byte arrives on the exact expiry cycle
        send(SYNC);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        idle(TO - 1, 1'b0);
        send(8'h77);
        check_val("t6_no_ferr", W'(bus.frame_error), W'(0));
        check_val("t6_bytes",   W'(bus.bytes_rcvd),  W'(6));
        idle(TO - 1, 1'b0);
        send(8'h78);
        check_val("t6_bytes2",  W'(bus.bytes_rcvd),  W'(7));
        idle(TO + 1, 1'b0);

        // Randomized traffic
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 3)) cycle(1'($urandom), 8'($urandom), 1'($urandom));
            if (phase == 2) cycle(1'b0, 8'h00, 1'b1);
            if (phase == 0) send(SYNC);
            for (int i = 0; i < WB; i++) begin
                if (phase != 1) break;
                r = $urandom_range(0, 99);
                if (r < 85)      idle($urandom_range(0, 3), 1'($urandom));
                else if (r < 95) idle(TO - 1, 1'($urandom));
                else             idle(TO + $urandom_range(0, 5), 1'($urandom));
                if (phase != 1) break;
                b = 8'($urandom);
                send(b);
            end
            if (phase == 2) begin
                repeat ($urandom_range(0, 4)) cycle(1'($urandom_range(0, 9) < 3), 8'($urandom), 1'b0);
                cycle(1'($urandom), 8'($urandom), 1'b1);
            end
        end
        idle(TO + 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
